// File: rtl/onehot_strobe_decoder_if.sv
// Handshake and strobe bundle for onehot_strobe_decoder.
// master = channel-index source / strobe consumer, slave = the decoder.
interface onehot_strobe_decoder_if;
  logic       in_valid;
  logic [2:0] in_code;
  logic       in_ready;
  logic [7:0] out_onehot;
  logic       out_valid;
  logic       out_done;
  logic       busy;

  modport master (
    output in_valid,
    output in_code,
    input  in_ready,
    input  out_onehot,
    input  out_valid,
    input  out_done,
    input  busy
  );

  modport slave (
    input  in_valid,
    input  in_code,
    output in_ready,
    output out_onehot,
    output out_valid,
    output out_done,
    output busy
  );
endinterface

// File: rtl/onehot_strobe_decoder.sv
// 3-to-8 binary-to-one-hot decoder: holds each strobe PULSE_CYCLES, then GAP_CYCLES of zeros.
// Optional one-entry pending buffer enabled by defining ONEHOT_DEC_PEND_EN.
module onehot_strobe_decoder #(
  parameter int unsigned PULSE_CYCLES = 4,
  parameter int unsigned GAP_CYCLES   = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  onehot_strobe_decoder_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
  localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] onehot_q, onehot_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;

  logic       in_ready;
  logic       xfer;
  logic       start;
  logic [2:0] start_code;

`ifdef ONEHOT_DEC_PEND_EN
  logic       pend_valid_q, pend_valid_d;
  logic [2:0] pend_code_q, pend_code_d;

  assign in_ready = !pend_valid_q;
`else
  assign in_ready = (state_q == IDLE);
`endif

  assign xfer = bus.in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    onehot_d   = onehot_q;
    start      = 1'b0;
    start_code = bus.in_code;
`ifdef ONEHOT_DEC_PEND_EN
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
`endif

    case (state_q)
      IDLE: begin
        if (xfer) start = 1'b1;
      end

      DRIVE: begin
        if (cnt_q == '0) begin
          state_d  = GAP;
          cnt_d    = GAP_LOAD;
          onehot_d = '0;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
`ifdef ONEHOT_DEC_PEND_EN
        if (xfer) begin
          pend_valid_d = 1'b1;
          pend_code_d  = bus.in_code;
        end
`endif
      end

      GAP: begin
        if (cnt_q == '0) begin
`ifdef ONEHOT_DEC_PEND_EN
          // A buffered code wins; otherwise a same-cycle transfer bypasses the buffer.
          if (pend_valid_q) begin
            start        = 1'b1;
            start_code   = pend_code_q;
            pend_valid_d = 1'b0;
          end else if (xfer) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
`ifdef ONEHOT_DEC_PEND_EN
          if (xfer) begin
            pend_valid_d = 1'b1;
            pend_code_d  = bus.in_code;
          end
`endif
        end
      end

      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        onehot_d = '0;
      end
    endcase

    if (start) begin
      state_d  = DRIVE;
      cnt_d    = PULSE_LOAD;
      onehot_d = 8'd1 << start_code;
    end

    valid_d = (onehot_d != '0);
    done_d  = (state_d == DRIVE) && (cnt_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

`ifdef ONEHOT_DEC_PEND_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_code_q  <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
    end
  end
`endif

  assign bus.in_ready   = in_ready;
  assign bus.out_onehot = onehot_q;
  assign bus.out_valid  = valid_q;
  assign bus.out_done   = done_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// Directed, table-driven bench for onehot_strobe_decoder (default and PULSE=1/GAP=1 instances).
module tb_onehot_strobe_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  onehot_strobe_decoder_if bus ();
  onehot_strobe_decoder_if bus1 ();

  onehot_strobe_decoder dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  onehot_strobe_decoder #(
    .PULSE_CYCLES (1),
    .GAP_CYCLES   (1)
  ) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

`ifdef ONEHOT_DEC_PEND_EN
  localparam int   SPACING        = 5;
  localparam logic READY_IN_STROBE = 1'b1;
`else
  localparam int   SPACING        = 6;
  localparam logic READY_IN_STROBE = 1'b0;
`endif

  typedef struct {
    logic [2:0] code;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk1("onehot0", $onehot0(bus.out_onehot), 1'b1);
      chk1("valid_eq_nonzero", bus.out_valid, bus.out_onehot != 8'h00);
      chk1("onehot0_p1", $onehot0(bus1.out_onehot), 1'b1);
      chk1("valid_eq_nonzero_p1", bus1.out_valid, bus1.out_onehot != 8'h00);
    end
  end

  task automatic strobe_check(input logic [2:0] code, input logic [7:0] exp);
    int w;
    w = 0;
    while (!bus.in_ready && w < 20) begin
      step();
      w++;
    end
    chk1("ready_before_xfer", bus.in_ready, 1'b1);
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      bus.in_code = 3'($urandom);
      chk8("strobe_onehot", bus.out_onehot, exp);
      chk1("strobe_valid", bus.out_valid, 1'b1);
      chk1("strobe_done", bus.out_done, c == 3);
      chk1("strobe_busy", bus.busy, 1'b1);
      chk1("strobe_ready", bus.in_ready, READY_IN_STROBE);
      step();
    end
    chk8("gap_onehot", bus.out_onehot, 8'h00);
    chk1("gap_valid", bus.out_valid, 1'b0);
    chk1("gap_done", bus.out_done, 1'b0);
    chk1("gap_busy", bus.busy, 1'b1);
    step();
    chk1("idle_busy", bus.busy, 1'b0);
    chk1("idle_ready", bus.in_ready, 1'b1);
  endtask

  task automatic run_seq(input string tag, input int n,
                         input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2,
                         input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    logic [2:0] codes [3];
    logic [7:0] exps  [3];
    int         starts [$];
    logic [7:0] svals  [$];
    logic [7:0] prev;
    int         idx;
    int         ready_low;
    logic       acc;
    int         m;
    codes = '{c0, c1, c2};
    exps  = '{e0, e1, e2};
    prev = 8'h00;
    idx = 0;
    ready_low = 0;
    for (int c = 0; c < 60; c++) begin
      if (prev == 8'h00 && bus.out_onehot != 8'h00) begin
        starts.push_back(c);
        svals.push_back(bus.out_onehot);
      end
      prev = bus.out_onehot;
`ifndef ONEHOT_DEC_PEND_EN
      chk1({tag, "_ready_vs_busy"}, bus.in_ready, !bus.busy);
`endif
      if (!bus.in_ready) ready_low++;
      if (idx < n) begin
        bus.in_valid = 1'b1;
        bus.in_code  = codes[idx];
      end else begin
        bus.in_valid = 1'b0;
      end
      acc = bus.in_valid && bus.in_ready;
      step();
      if (acc) idx++;
    end
    bus.in_valid = 1'b0;
    chki({tag, "_num_strobes"}, starts.size(), n);
    m = (starts.size() < n) ? starts.size() : n;
    for (int i = 0; i < m; i++) begin
      chk8({tag, "_strobe_value"}, svals[i], exps[i]);
      if (i > 0) chki({tag, "_start_spacing"}, starts[i] - starts[i-1], SPACING);
    end
    chk1({tag, "_ready_dropped"}, ready_low > 0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{code: 3'd3, exp: 8'h08};
    vecs[1] = '{code: 3'd0, exp: 8'h01};
    vecs[2] = '{code: 3'd1, exp: 8'h02};
    vecs[3] = '{code: 3'd2, exp: 8'h04};
    vecs[4] = '{code: 3'd3, exp: 8'h08};
    vecs[5] = '{code: 3'd4, exp: 8'h10};
    vecs[6] = '{code: 3'd5, exp: 8'h20};
    vecs[7] = '{code: 3'd6, exp: 8'h40};

    bus.in_valid  = 1'b0;
    bus.in_code   = 3'd0;
    bus1.in_valid = 1'b0;
    bus1.in_code  = 3'd0;

    #2;
    chk8("rst_onehot", bus.out_onehot, 8'h00);
    chk1("rst_valid", bus.out_valid, 1'b0);
    chk1("rst_done", bus.out_done, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_ready", bus.in_ready, 1'b1);
    chk1("rst_ready_p1", bus1.in_ready, 1'b1);
    step();
    step();
    rst = 1'b0;

    foreach (vecs[i]) strobe_check(vecs[i].code, vecs[i].exp);
    strobe_check(3'd7, 8'h80);

    // reset mid-strobe, with a second code offered (buffered when pending is enabled)
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd5;
    step();
    bus.in_code  = 3'd2;
    step();
    bus.in_valid = 1'b0;
    step();
    chk8("pre_rst_onehot", bus.out_onehot, 8'h20);
    #2;
    rst = 1'b1;
    #1;
    chk8("async_rst_onehot", bus.out_onehot, 8'h00);
    chk1("async_rst_valid", bus.out_valid, 1'b0);
    chk1("async_rst_busy", bus.busy, 1'b0);
    chk1("async_rst_done", bus.out_done, 1'b0);
    step();
    rst = 1'b0;
    chk1("post_rst_ready", bus.in_ready, 1'b1);
    for (int c = 0; c < 8; c++) begin
      chk8("post_rst_no_strobe", bus.out_onehot, 8'h00);
      chk1("post_rst_idle", bus.busy, 1'b0);
      step();
    end

    run_seq("hold_6_1", 2, 3'd6, 3'd1, 3'd0, 8'h40, 8'h02, 8'h00);
    run_seq("seq_2_7_4", 3, 3'd2, 3'd7, 3'd4, 8'h04, 8'h80, 8'h10);

    bus1.in_valid = 1'b1;
    bus1.in_code  = 3'd0;
    step();
    bus1.in_valid = 1'b0;
    bus1.in_code  = 3'd7;
    chk8("p1_onehot", bus1.out_onehot, 8'h01);
    chk1("p1_valid", bus1.out_valid, 1'b1);
    chk1("p1_done", bus1.out_done, 1'b1);
    step();
    chk8("p1_gap_onehot", bus1.out_onehot, 8'h00);
    chk1("p1_gap_done", bus1.out_done, 1'b0);
    chk1("p1_gap_busy", bus1.busy, 1'b1);
    step();
    chk1("p1_idle_busy", bus1.busy, 1'b0);
    chk1("p1_idle_ready", bus1.in_ready, 1'b1);
    chk8("p1_idle_onehot", bus1.out_onehot, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_strobe_decoder.md
# onehot_strobe_decoder

Sequential 3-to-8 binary-to-one-hot decoder with a valid/ready input handshake and timed output strobes. It is the counterpart of the one-hot-to-binary encoder. A binary channel code is accepted on the input side. The block drives the matching one-hot line for a fixed number of cycles, then enforces a dead gap with all lines low. It sits between control logic that issues channel indices and the one-hot select/enable lines that fan out to eight peripherals.

## Interface
Parameters:
- `PULSE_CYCLES`, default 4: cycles each one-hot strobe is held; legal range 1..255.
- `GAP_CYCLES`, default 1: all-zero cycles after each strobe; legal range 1..255.

Ports (reset is asynchronous and active-high; one clock):
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: `in_code` is valid.
- `in_code` input 3: binary channel index 0..7.
- `in_ready` output 1: block can accept a code this cycle.
- `out_onehot` output 8: registered one-hot strobe; bit `in_code` is high during a strobe, otherwise all zero.
- `out_valid` output 1: registered; high exactly while `out_onehot` is non-zero.
- `out_done` output 1: registered; single-cycle pulse coincident with the last strobe cycle.
- `busy` output 1: state is not IDLE.

## Operation
- FSM states: IDLE, DRIVE, GAP. Counter width is 8 bits.
- Reset value of every output while `rst` is high:
  - `out_onehot`=0, `out_valid`=0, `out_done`=0, `busy`=0.
  - `in_ready`=1; it is combinational from state.
  - State is IDLE, the counter is 0, and the pending buffer is empty.
- A transfer occurs on a rising edge where `in_valid` and `in_ready` are both high.
- IDLE plus transfer:
  - Go to DRIVE.
  - Next cycle, `out_onehot` = 8'b1 << `in_code` and `out_valid`=1.
  - The counter loads `PULSE_CYCLES`-1.
- DRIVE:
  - Hold `out_onehot`.
  - Decrement the counter each cycle.
  - In the cycle the counter is 0, `out_done`=1; on the next edge go to GAP, with the counter loaded to `GAP_CYCLES`-1.
- GAP:
  - `out_onehot`=0 and `out_valid`=0.
  - At counter 0, the next state is chosen as described under Configuration; the default is IDLE.
- Decoding is total: every 3-bit code maps to exactly one line. There is no invalid input code.
- `in_code` is sampled only on transfer. Changes at other times have no effect.
- Reset asserted mid-DRIVE or mid-GAP:
  - Outputs clear asynchronously, the same cycle.
  - Any captured or pending code is discarded.

## Timing
- Latency: a transfer at edge N means `out_onehot` is valid after edge N (cycle N+1).
- Each strobe lasts exactly `PULSE_CYCLES` cycles, followed by exactly `GAP_CYCLES` zero cycles.
- Minimum spacing between strobe starts is `PULSE_CYCLES`+`GAP_CYCLES` cycles.
- `in_ready` without the macro is high only in IDLE.
- The back-to-back minimum for the base build is `PULSE_CYCLES`+`GAP_CYCLES`+1 cycles, because IDLE costs one cycle.
- `in_valid` held high while `in_ready`=0: no transfer occurs. The source must hold `in_code` stable.
- Reset release is synchronous to `clk` externally. The first transfer is allowed on the first edge after deassertion.

## Configuration
- Macro `ONEHOT_DEC_PEND_EN`.
- Defined: adds a one-entry pending buffer.
  - `in_ready` = !pend_valid in every state.
  - A transfer in DRIVE or GAP stores the code into pending.
  - At the end of GAP (counter 0):
    - Pending full: go directly to DRIVE with the pending code and empty the buffer.
    - Pending empty with a simultaneous transfer: bypass straight to DRIVE with `in_code`.
    - Otherwise: go to IDLE.
  - Strobe starts can then be exactly `PULSE_CYCLES`+`GAP_CYCLES` apart.
- Undefined:
  - No pending storage.
  - `in_ready` = (state==IDLE).
  - GAP always returns to IDLE.

## Test plan
- Reset check: assert `rst` mid-strobe with `in_code`=5 → `out_onehot`=8'h00, `out_valid`=0, `busy`=0 the same cycle. After release, `in_ready`=1.
- Single transfer with `in_code`=3 and defaults → `out_onehot`=8'h08 for 4 cycles starting one cycle after the transfer. `out_done` is high on the 4th cycle only. This is followed by 1 zero cycle, then IDLE.
- Sweep codes 0..7 sequentially → the strobes are 8'h01, 8'h02, …, 8'h80 in order. Each strobe is 4 cycles long, and no two bits are ever high at once.
- Base build, `in_valid` held high with code 6 then code 1 → code 1 is accepted only after the return to IDLE. The strobe starts are 6 cycles apart, and `in_ready` is low during DRIVE and GAP.
- `ONEHOT_DEC_PEND_EN`, with codes 2, 7, 4 offered continuously → strobes 8'h04, 8'h80, 8'h10 start exactly 5 cycles apart. `in_ready` drops while the pending buffer is full.
- `PULSE_CYCLES`=1 and `GAP_CYCLES`=1 with `in_code`=0 → a 1-cycle 8'h01 with `out_done` high in the same cycle, then 1 zero cycle.
